// File: rtl/exc_seq.sv
// Exception / eret sequencer: arbitrates M-stage exceptions, interrupts and eret into CP0 update and PC redirect.
// Optional EXC_SEQ_STATS_EN adds a committed-exception counter output (exc_count).
module exc_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic        m_exc,
    input  logic [4:0]  m_excode,
    input  logic        m_bd,
    input  logic [31:0] m_pc,
    input  logic        m_eret,
    input  logic        hw_int,
    input  logic        exl,
    input  logic [31:0] epc_in,
    input  logic        md_busy,
`ifdef EXC_SEQ_STATS_EN
    output logic [31:0] exc_count,
`endif
    output logic        cp0_exl_set,
    output logic        cp0_exl_clr,
    output logic [4:0]  cp0_excode,
    output logic        cp0_bd,
    output logic [31:0] cp0_epc,
    output logic        stall,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DRAIN    = 3'd1,
        ST_COMMIT   = 3'd2,
        ST_REDIRECT = 3'd3,
        ST_ERET     = 3'd4
    } state_t;

    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

    state_t      state_r;
    logic        pend_bd_r;
    logic [31:0] pend_epc_r;

    logic        take_s;
    logic [4:0]  code_s;
    logic [31:0] epc_s;

    // A delay-slot instruction restarts at its branch, one word back.
    function automatic logic [31:0] epc_of(input logic bd, input logic [31:0] pc);
        if (bd) begin
            return pc - 32'd4;
        end else begin
            return pc;
        end
    endfunction

    // Take decision and selected cause for the instruction currently in M.
    always_comb begin
        take_s = !exl && m_valid && (hw_int || m_exc);
        if (hw_int) begin
            code_s = 5'd0;
        end else begin
            code_s = m_excode;
        end
        epc_s = epc_of(m_bd, m_pc);
    end

    // Sequencer state and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            pend_bd_r      <= 1'b0;
            pend_epc_r     <= 32'd0;
            cp0_exl_set    <= 1'b0;
            cp0_exl_clr    <= 1'b0;
            cp0_excode     <= 5'd0;
            cp0_bd         <= 1'b0;
            cp0_epc        <= 32'd0;
            stall          <= 1'b0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
        end else begin
            cp0_exl_set    <= 1'b0;
            cp0_exl_clr    <= 1'b0;
            stall          <= 1'b0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            case (state_r)
                ST_IDLE: begin
                    if (take_s) begin
                        if (hw_int && md_busy) begin
                            // Interrupt must wait for mult/div so its result is not lost.
                            state_r    <= ST_DRAIN;
                            stall      <= 1'b1;
                            pend_bd_r  <= m_bd;
                            pend_epc_r <= epc_s;
                        end else begin
                            state_r     <= ST_COMMIT;
                            cp0_exl_set <= 1'b1;
                            cp0_excode  <= code_s;
                            cp0_bd      <= m_bd;
                            cp0_epc     <= epc_s;
                            stall       <= 1'b1;
                            flush       <= 1'b1;
                        end
                    end else if (m_eret && exl && m_valid) begin
                        state_r        <= ST_ERET;
                        cp0_exl_clr    <= 1'b1;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= epc_in;
                        flush          <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (m_valid && m_exc) begin
                        state_r     <= ST_COMMIT;
                        cp0_exl_set <= 1'b1;
                        cp0_excode  <= m_excode;
                        cp0_bd      <= m_bd;
                        cp0_epc     <= epc_s;
                        stall       <= 1'b1;
                        flush       <= 1'b1;
                    end else if (!hw_int) begin
                        state_r <= ST_IDLE;
                    end else if (!md_busy) begin
                        state_r     <= ST_COMMIT;
                        cp0_exl_set <= 1'b1;
                        cp0_excode  <= 5'd0;
                        cp0_bd      <= pend_bd_r;
                        cp0_epc     <= pend_epc_r;
                        stall       <= 1'b1;
                        flush       <= 1'b1;
                    end else begin
                        state_r <= ST_DRAIN;
                        stall   <= 1'b1;
                    end
                end
                ST_COMMIT: begin
                    state_r        <= ST_REDIRECT;
                    redirect_valid <= 1'b1;
                    redirect_pc    <= EXC_VECTOR;
                    flush          <= 1'b1;
                end
                ST_REDIRECT: begin
                    state_r <= ST_IDLE;
                end
                ST_ERET: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef EXC_SEQ_STATS_EN
    // Count each committed exception; free-running wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exc_count <= 32'd0;
        end else if (cp0_exl_set) begin
            exc_count <= exc_count + 32'd1;
        end else begin
            exc_count <= exc_count;
        end
    end
`endif

endmodule

// File: tb/tb_exc_seq.sv
// Directed self-checking bench for exc_seq; expected values are hand-computed constants.
module tb_exc_seq;

    logic        clk;
    logic        reset;
    logic        m_valid;
    logic        m_exc;
    logic [4:0]  m_excode;
    logic        m_bd;
    logic [31:0] m_pc;
    logic        m_eret;
    logic        hw_int;
    logic        exl;
    logic [31:0] epc_in;
    logic        md_busy;
    logic        cp0_exl_set;
    logic        cp0_exl_clr;
    logic [4:0]  cp0_excode;
    logic        cp0_bd;
    logic [31:0] cp0_epc;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef EXC_SEQ_STATS_EN
    logic [31:0] exc_count;
`endif

    int errors = 0;
    int checks = 0;

    exc_seq dut (
        .clk(clk), .reset(reset), .m_valid(m_valid), .m_exc(m_exc),
        .m_excode(m_excode), .m_bd(m_bd), .m_pc(m_pc), .m_eret(m_eret),
        .hw_int(hw_int), .exl(exl), .epc_in(epc_in), .md_busy(md_busy),
`ifdef EXC_SEQ_STATS_EN
        .exc_count(exc_count),
`endif
        .cp0_exl_set(cp0_exl_set), .cp0_exl_clr(cp0_exl_clr),
        .cp0_excode(cp0_excode), .cp0_bd(cp0_bd), .cp0_epc(cp0_epc),
        .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_valid = 1'b0; m_exc = 1'b0; m_excode = 5'd0; m_bd = 1'b0;
        m_pc = 32'd0; m_eret = 1'b0; hw_int = 1'b0; exl = 1'b0;
        epc_in = 32'd0; md_busy = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_exl_set"}, {31'd0, cp0_exl_set}, 32'd0);
        chk({tag, "_exl_clr"}, {31'd0, cp0_exl_clr}, 32'd0);
        chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
        chk({tag, "_flush"}, {31'd0, flush}, 32'd0);
        chk({tag, "_rvalid"}, {31'd0, redirect_valid}, 32'd0);
        chk({tag, "_rpc"}, redirect_pc, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        #3;
        chk_quiet("rst");
        chk("rst_excode", {27'd0, cp0_excode}, 32'd0);
        chk("rst_epc", cp0_epc, 32'd0);
        chk("rst_bd", {31'd0, cp0_bd}, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Plain sync exception, not in delay slot
        m_valid = 1'b1; m_exc = 1'b1; m_excode = 5'd4; m_pc = 32'h3008;
        tick();
        idle_inputs();
        chk("e1_exl_set", {31'd0, cp0_exl_set}, 32'd1);
        chk("e1_excode", {27'd0, cp0_excode}, 32'd4);
        chk("e1_epc", cp0_epc, 32'h3008);
        chk("e1_bd", {31'd0, cp0_bd}, 32'd0);
        chk("e1_flush", {31'd0, flush}, 32'd1);
        chk("e1_stall", {31'd0, stall}, 32'd1);
        chk("e1_rvalid0", {31'd0, redirect_valid}, 32'd0);
        tick();
        chk("e1_rvalid", {31'd0, redirect_valid}, 32'd1);
        chk("e1_rpc", redirect_pc, 32'h4180);
        chk("e1_exl_set0", {31'd0, cp0_exl_set}, 32'd0);
        chk("e1_hold_code", {27'd0, cp0_excode}, 32'd4);
        tick();
        chk_quiet("e1_idle");
        chk("e1_hold_epc", cp0_epc, 32'h3008);
`ifdef EXC_SEQ_STATS_EN
        chk("e1_count", exc_count, 32'd1);
`endif

        // Delay-slot exception: EPC backs up to the branch
        m_valid = 1'b1; m_exc = 1'b1; m_excode = 5'd4; m_pc = 32'h300C; m_bd = 1'b1;
        tick();
        idle_inputs();
        chk("bd_bd", {31'd0, cp0_bd}, 32'd1);
        chk("bd_epc", cp0_epc, 32'h3008);
        tick();
        tick();

        // Interrupt waits for mult/div: 3 drain cycles then commit code 0
        m_valid = 1'b1; hw_int = 1'b1; md_busy = 1'b1; m_pc = 32'h3100;
        tick();
        chk("dr1_stall", {31'd0, stall}, 32'd1);
        chk("dr1_exl_set", {31'd0, cp0_exl_set}, 32'd0);
        tick();
        chk("dr2_stall", {31'd0, stall}, 32'd1);
        tick();
        chk("dr3_stall", {31'd0, stall}, 32'd1);
        chk("dr3_flush", {31'd0, flush}, 32'd0);
        md_busy = 1'b0;
        tick();
        idle_inputs();
        chk("dr_exl_set", {31'd0, cp0_exl_set}, 32'd1);
        chk("dr_excode", {27'd0, cp0_excode}, 32'd0);
        chk("dr_epc", cp0_epc, 32'h3100);
        tick();
        chk("dr_rpc", redirect_pc, 32'h4180);
        tick();

        // Interrupt withdrawn during drain: no commit
        m_valid = 1'b1; hw_int = 1'b1; md_busy = 1'b1; m_pc = 32'h3120;
        tick();
        chk("ab_stall", {31'd0, stall}, 32'd1);
        hw_int = 1'b0;
        tick();
        chk_quiet("ab_idle");
        idle_inputs();
        tick();
        chk_quiet("ab_idle2");

        // Sync exception preempts drain
        m_valid = 1'b1; hw_int = 1'b1; md_busy = 1'b1; m_pc = 32'h3200;
        tick();
        m_exc = 1'b1; m_excode = 5'd10; m_pc = 32'h3204;
        tick();
        idle_inputs();
        chk("pre_exl_set", {31'd0, cp0_exl_set}, 32'd1);
        chk("pre_excode", {27'd0, cp0_excode}, 32'd10);
        chk("pre_epc", cp0_epc, 32'h3204);
        tick();
        tick();

        // eret with EXL set
        m_valid = 1'b1; m_eret = 1'b1; exl = 1'b1; epc_in = 32'h3010;
        tick();
        idle_inputs();
        chk("er_exl_clr", {31'd0, cp0_exl_clr}, 32'd1);
        chk("er_rvalid", {31'd0, redirect_valid}, 32'd1);
        chk("er_rpc", redirect_pc, 32'h3010);
        chk("er_flush", {31'd0, flush}, 32'd1);
        chk("er_exl_set", {31'd0, cp0_exl_set}, 32'd0);
        tick();
        chk_quiet("er_idle");

        // eret without EXL is ignored
        m_valid = 1'b1; m_eret = 1'b1; epc_in = 32'h3010;
        tick();
        chk_quiet("er0");
        idle_inputs();
        tick();

        // Interrupt beats sync exception
        m_valid = 1'b1; hw_int = 1'b1; m_exc = 1'b1; m_excode = 5'd12; m_pc = 32'h3300;
        tick();
        idle_inputs();
        chk("pri_exl_set", {31'd0, cp0_exl_set}, 32'd1);
        chk("pri_excode", {27'd0, cp0_excode}, 32'd0);
        tick();
        tick();

        // Same with EXL set: nothing happens
        m_valid = 1'b1; hw_int = 1'b1; m_exc = 1'b1; m_excode = 5'd12; exl = 1'b1;
        tick();
        chk_quiet("exl1");
        tick();
        chk_quiet("exl2");
        idle_inputs();

        // Exception and eret together with EXL clear: exception wins
        m_valid = 1'b1; m_exc = 1'b1; m_eret = 1'b1; m_excode = 5'd8; m_pc = 32'h3400;
        tick();
        idle_inputs();
        chk("ee_exl_set", {31'd0, cp0_exl_set}, 32'd1);
        chk("ee_exl_clr", {31'd0, cp0_exl_clr}, 32'd0);
        chk("ee_excode", {27'd0, cp0_excode}, 32'd8);
        tick();
        tick();

        // Reset during COMMIT aborts the sequence
        m_valid = 1'b1; m_exc = 1'b1; m_excode = 5'd4; m_pc = 32'h3008;
        tick();
        idle_inputs();
        chk("mr_commit", {31'd0, cp0_exl_set}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk_quiet("mr_rst");
        chk("mr_excode", {27'd0, cp0_excode}, 32'd0);
        chk("mr_epc", cp0_epc, 32'd0);
`ifdef EXC_SEQ_STATS_EN
        chk("mr_count", exc_count, 32'd0);
`endif
        tick();
        reset = 1'b1;
        tick();
        chk_quiet("mr_after1");
        tick();
        chk_quiet("mr_after2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
